load_store_unit: RTL and testbench

- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the execute stage and drives addr/wr_data/wr_enable/rd_enable toward the 64-bit word-addressed data memory.
- The data memory writes only full 64-bit words, so sub-word stores are done as read-modify-write.
- Sub-word loads are extracted from the word and sign- or zero-extended; misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 41 ++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_t;

    function automatic logic [3:0] size_bytes(lsu_size_t size);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // An access is aligned when the byte offset is a multiple of its size.
    function automatic logic is_misaligned(lsu_size_t size, logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a 64-bit memory word and right-aligned data.
// Produces the read-modify-write store word and the extended load result.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] word,
    input  logic [63:0] wdata,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] store_word,
    output logic [63:0] load_data
);

    logic [3:0]  nbytes;
    logic [5:0]  shamt;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] shifted;

    // Merge store bytes into the word and extract/extend load bytes.
    always_comb begin
        nbytes     = size_bytes(lsu_size_t'(size));
        shamt      = {off, 3'b000};
        size_mask  = (nbytes == 4'd8) ? {64{1'b1}}
                                      : ((64'd1 << {nbytes[2:0], 3'b000}) - 64'd1);
        lane_mask  = size_mask << shamt;
        store_word = (word & ~lane_mask) | ((wdata & size_mask) << shamt);
        shifted    = word >> shamt;
        case (lsu_size_t'(size))
            SZ_B:    load_data = is_unsigned ? {56'd0, shifted[7:0]}
                                             : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = is_unsigned ? {48'd0, shifted[15:0]}
                                             : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    load_data = is_unsigned ? {32'd0, shifted[31:0]}
                                             : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory interface: one request at a time,
// sub-word stores as read-modify-write on the 64-bit word memory.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request; checks alignment/range on accept
// ST_READ  | read strobe; word captured at the end of the cycle
// ST_WRITE | write strobe with merged (or full dword) store data
// ST_RESP  | single-cycle response pulse with load data or error flags
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned mem_size = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wr_data,
    output logic        mem_wr_enable,
    output logic        mem_rd_enable,
    input  logic [63:0] mem_rd_data
);

    lsu_state_t  state_q, state_d;
    logic        is_store_q, is_store_d;
    lsu_size_t   size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] word_q, word_d;
    logic        misaligned_q, misaligned_d;
    logic        fault_q, fault_d;

    logic [63:0] store_word;
    logic [63:0] load_data;
    logic        req_mis;
    logic        req_flt;

    lsu_lane_align u_lane_align (
        .word        (word_q),
        .wdata       (wdata_q),
        .off         (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .store_word  (store_word),
        .load_data   (load_data)
    );

    // State and request registers; async reset discards any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 64'd0;
            word_q       <= 64'd0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state logic: accept and classify in IDLE, then walk the access.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        misaligned_d = misaligned_q;
        fault_d      = fault_q;
        req_mis      = is_misaligned(lsu_size_t'(req_size), req_addr[2:0]);
        req_flt      = ({3'b000, req_addr[31:3]} >= 32'(mem_size));
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_store_d   = req_is_store;
                    size_d       = lsu_size_t'(req_size);
                    unsigned_d   = req_unsigned;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    misaligned_d = req_mis;
                    fault_d      = req_flt;
                    if (req_mis || req_flt)
                        state_d = ST_RESP;
                    else if (req_is_store && (lsu_size_t'(req_size) == SZ_D))
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                word_d  = mem_rd_data;
                state_d = is_store_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the latched request.
    always_comb begin
        req_ready       = (state_q == ST_IDLE);
        mem_rd_enable   = (state_q == ST_READ);
        mem_wr_enable   = (state_q == ST_WRITE);
        mem_addr        = {addr_q[31:3], 3'b000};
        mem_wr_data     = (state_q == ST_WRITE) ? store_word : 64'd0;
        resp_valid      = (state_q == ST_RESP);
        resp_misaligned = (state_q == ST_RESP) && misaligned_q;
        resp_fault      = (state_q == ST_RESP) && fault_q;
        resp_rdata      = ((state_q == ST_RESP) && !is_store_q && !misaligned_q && !fault_q)
                          ? load_data : 64'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus hand sequences
// for back-pressure and reset during a write.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic        mem_wr_enable;
    logic        mem_rd_enable;
    logic [63:0] mem_rd_data;

    logic [63:0] mem [0:255];
    logic        mem_load;

    int n_chk  = 0;
    int n_pass = 0;
    int n_acc  = 0;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        mis;
        logic        flt;
        int          lat;
        logic [63:0] wr;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[24];

    load_store_unit #(.mem_size(256)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_fault      (resp_fault),
        .mem_addr        (mem_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_wr_enable   (mem_wr_enable),
        .mem_rd_enable   (mem_rd_enable),
        .mem_rd_data     (mem_rd_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr[10:3]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
            mem[0]   <= 64'h0000_0000_8000_0000;
            mem[1]   <= 64'h19;
            mem[5]   <= 64'h5050;
            mem[255] <= 64'h5555;
        end else if (mem_wr_enable) begin
            mem[mem_addr[10:3]] <= mem_wr_data;
        end
    end

    always @(posedge clk) if (req_valid && req_ready) n_acc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Response scoreboard.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_flags", {62'd0, resp_misaligned, resp_fault}, {62'd0, e.mis, e.flt});
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int   lat = 0;
        int   wr_cyc = 0;
        logic rd_seen = 1'b0, wr_seen = 1'b0, both = 1'b0;
        logic [63:0] wr_data = 64'd0;
        logic err, exp_rd, exp_wr;
        exp_t e;
        err    = v.mis | v.flt;
        exp_wr = !err && v.st;
        exp_rd = !err && !(v.st && v.sz == 2'd3);
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), {63'd0, req_ready}, 64'd1);
        req_valid    = 1'b1;
        req_is_store = v.st;
        req_size     = v.sz;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        e.rdata = v.rdata; e.mis = v.mis; e.flt = v.flt;
        sb_q.push_back(e);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_rd_enable) rd_seen = 1'b1;
            if (mem_wr_enable) begin wr_seen = 1'b1; wr_data = mem_wr_data; wr_cyc = c; end
            if (mem_rd_enable && mem_wr_enable) both = 1'b1;
            if (resp_valid) begin lat = c; break; end
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d strobes", idx), {61'd0, rd_seen, wr_seen, both},
            {61'd0, exp_rd, exp_wr, 1'b0});
        if (exp_wr) begin
            chk($sformatf("v%0d wr_cycle", idx), 64'(wr_cyc), (v.sz == 2'd3) ? 64'd1 : 64'd2);
            chk($sformatf("v%0d wr_data", idx), wr_data, v.wr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   acc0;
        logic resp_seen;
        rst = 1'b1; mem_load = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;

        //              st  sz  uns addr      wdata                   rdata                   mis  flt  lat wr
        vecs[0]  = '{1'b0, 2'd3, 1'b0, 32'd8,     64'd0,                 64'h19,                 1'b0,1'b0, 2, 64'd0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'd3,     64'd0,                 64'hFFFF_FFFF_FFFF_FF80,1'b0,1'b0, 2, 64'd0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'd3,     64'd0,                 64'h80,                 1'b0,1'b0, 2, 64'd0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'd2,     64'd0,                 64'hFFFF_FFFF_FFFF_8000,1'b0,1'b0, 2, 64'd0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'd0,     64'd0,                 64'hFFFF_FFFF_8000_0000,1'b0,1'b0, 2, 64'd0};
        vecs[5]  = '{1'b0, 2'd2, 1'b1, 32'd0,     64'd0,                 64'h8000_0000,          1'b0,1'b0, 2, 64'd0};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'd9,     64'hAB,                64'd0,                  1'b0,1'b0, 3, 64'hAB19};
        vecs[7]  = '{1'b0, 2'd3, 1'b0, 32'd8,     64'd0,                 64'hAB19,               1'b0,1'b0, 2, 64'd0};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'd3,     64'd0,                 64'd0,                  1'b1,1'b0, 1, 64'd0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'd2048,  64'd0,                 64'd0,                  1'b0,1'b1, 1, 64'd0};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h802,   64'd0,                 64'd0,                  1'b1,1'b1, 1, 64'd0};
        vecs[11] = '{1'b1, 2'd3, 1'b0, 32'd16,    64'h1234,              64'd0,                  1'b0,1'b0, 2, 64'h1234};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'd16,    64'd0,                 64'h1234,               1'b0,1'b0, 2, 64'd0};
        vecs[13] = '{1'b1, 2'd1, 1'b0, 32'd14,    64'hFFFF_FFFF_FFFF_CAFE,64'd0,                 1'b0,1'b0, 3, 64'hCAFE_0000_0000_AB19};
        vecs[14] = '{1'b0, 2'd1, 1'b1, 32'd14,    64'd0,                 64'hCAFE,               1'b0,1'b0, 2, 64'd0};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 32'd14,    64'd0,                 64'hFFFF_FFFF_FFFF_CAFE,1'b0,1'b0, 2, 64'd0};
        vecs[16] = '{1'b1, 2'd2, 1'b0, 32'd20,    64'h1111_1111_DEAD_BEEF,64'd0,                 1'b0,1'b0, 3, 64'hDEAD_BEEF_0000_1234};
        vecs[17] = '{1'b0, 2'd2, 1'b1, 32'd20,    64'd0,                 64'hDEAD_BEEF,          1'b0,1'b0, 2, 64'd0};
        vecs[18] = '{1'b0, 2'd3, 1'b0, 32'd2040,  64'd0,                 64'h5555,               1'b0,1'b0, 2, 64'd0};
        vecs[19] = '{1'b1, 2'd0, 1'b0, 32'd4096,  64'hFF,                64'd0,                  1'b0,1'b1, 1, 64'd0};
        vecs[20] = '{1'b1, 2'd3, 1'b0, 32'd4,     64'h99,                64'd0,                  1'b1,1'b0, 1, 64'd0};
        vecs[21] = '{1'b0, 2'd0, 1'b0, 32'd15,    64'd0,                 64'hFFFF_FFFF_FFFF_FFCA,1'b0,1'b0, 2, 64'd0};
        vecs[22] = '{1'b0, 2'd3, 1'b0, 32'd0,     64'd0,                 64'h0000_0000_8000_0000,1'b0,1'b0, 2, 64'd0};
        vecs[23] = '{1'b0, 2'd2, 1'b0, 32'd2044,  64'd0,                 64'd0,                  1'b0,1'b0, 2, 64'd0};

        repeat (3) @(negedge clk);
        chk("reset ready", {63'd0, req_ready}, 64'd1);
        chk("reset strobes/flags",
            {59'd0, resp_valid, resp_misaligned, resp_fault, mem_wr_enable, mem_rd_enable}, 64'd0);
        chk("reset resp_rdata", resp_rdata, 64'd0);
        chk("reset mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("reset mem_wr_data", mem_wr_data, 64'd0);
        rst = 1'b0; mem_load = 1'b0;

        for (int i = 0; i < 24; i++) run_vec(i, vecs[i]);

        // Request held valid through the busy window: exactly one accept.
        @(negedge clk);
        acc0 = n_acc;
        req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 32'd24; req_wdata = 64'h77;
        sb_q.push_back('{64'd0, 1'b0, 1'b0});
        @(negedge clk);
        chk("busy c1 ready", {63'd0, req_ready}, 64'd0);
        chk("busy c1 wr", {62'd0, mem_wr_enable, mem_rd_enable}, 64'd2);
        @(negedge clk);
        chk("busy c2 ready", {63'd0, req_ready}, 64'd0);
        chk("busy c2 resp", {63'd0, resp_valid}, 64'd1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy accepts", 64'(n_acc - acc0), 64'd1);
        chk("busy idle ready", {63'd0, req_ready}, 64'd1);
        chk("busy mem word", mem[3], 64'h77);

        // Reset asserted in the middle of the WRITE cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd41; req_wdata = 64'h11;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst c1 read", {62'd0, mem_wr_enable, mem_rd_enable}, 64'd1);
        @(negedge clk);
        chk("rst c2 write", {62'd0, mem_wr_enable, mem_rd_enable}, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("rst wr drop", {63'd0, mem_wr_enable}, 64'd0);
        chk("rst ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        resp_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) resp_seen = 1'b1;
        end
        chk("rst no resp", {63'd0, resp_seen}, 64'd0);
        chk("rst mem unchanged", mem[5], 64'h5050);
        chk("rst ready after", {63'd0, req_ready}, 64'd1);
        run_vec(100, '{1'b0, 2'd3, 1'b0, 32'd40, 64'd0, 64'h5050, 1'b0, 1'b0, 2, 64'd0});

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
